uart_rx_ovs: RTL
================

Name: uart_rx_ovs

Overview:
Parametrised UART receiver; successor to the fixed-format 8N1 receiver. Adds a 2-flop input synchroniser, 16x oversampling with 3-sample majority vote, a runtime baud divisor, and optional even/odd parity. Also adds 1 or 2 stop bits, false-start rejection, framing/parity/break/overrun flags, and a valid/ready output buffer. Sits between the pad-side serial line and the UART register/FIFO layer.

Parameters:
DLEN, 8, data bits per frame (5..9), LSB received first
OVS, 16, oversample ticks per bit (even, >=8)
DIVW, 16, width of i_div
SYNC, 2, synchroniser flops on i_rxs (>=2)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
i_rxs  in  1  async serial line, idle high
i_div  in  DIVW  clocks per oversample tick minus 1 (0 = tick every clk)
i_par_en  in  1  parity bit present
i_par_odd  in  1  1 = odd parity, 0 = even
i_stop2  in  1  1 = two stop bits
o_rvalid  out  1  frame held in output buffer
i_rready  in  1  consumer accepts buffer
o_rdata  out  DLEN  received data
o_perr  out  1  parity error for buffered frame
o_ferr  out  1  framing error (a stop bit sampled 0)
o_brk  out  1  break: data, parity and first stop bit all 0
o_ovr  out  1  one-cycle pulse: completed frame dropped, buffer full

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM IDLE, counters 0, synchroniser flops 1.
- rxs = last synchroniser stage; all logic uses rxs only.
- Tick gen: div_ct counts 0..div_q and wraps; tick asserts in the cycle div_ct==div_q. Counter is held 0 in IDLE.
- Oversample counter os_ct: 0..OVS-1, advances on tick, wraps.
- Majority vote: samples taken at os_ct = OVS/2-1, OVS/2, OVS/2+1. Bit value = 2-of-3. Decision is made on the tick where os_ct = OVS/2+1; bit period ends on wrap.
- Config latch: i_div, i_par_en, i_par_odd, i_stop2 latched on leaving IDLE. Mid-frame changes take effect next frame only.
- FSM:
  - IDLE: rxs==0 -> START; clear div_ct/os_ct.
  - START: at vote, 1 -> IDLE (false start, no flags); 0 -> continue to bit end -> DATA.
  - DATA: shift vote into shreg MSB side (LSB-first assembly); after DLEN bits -> PARITY if par_en, else STOP1.
  - PARITY: store vote; expected = XOR(data) XOR par_odd; perr = vote != expected.
  - STOP1: at vote -> if stop2 and vote==1, go to STOP2 at bit end. Otherwise complete frame at the vote tick (no wait for bit end) and go to IDLE. If vote==0 -> BRKWAIT instead of IDLE.
  - STOP2: at vote, complete frame; 0 -> ferr, go BRKWAIT; 1 -> IDLE.
  - BRKWAIT: stay until rxs==1, then IDLE. No new frame is detected while waiting.
- Frame completion (1-cycle internal event): ferr = any stop vote 0; brk = data==0 && parity vote==0 (if enabled) && STOP1 vote==0.
- Output buffer:
  - If !o_rvalid, or o_rvalid && i_rready in the same cycle: next cycle loads o_rdata/o_perr/o_ferr/o_brk and sets o_rvalid=1.
  - Else frame dropped, buffer unchanged, o_ovr=1 for one cycle.
  - o_rvalid clears the cycle after i_rready with no simultaneous completion.
  - Flags are held stable while o_rvalid.
- Latency: o_rvalid rises 1 clk after the last stop-bit vote tick.
- div_q=0: tick every clk; one bit = OVS clks.
- rstn asserted mid-frame: immediate return to reset state; partial frame discarded, no flags.

Test Plan:
- OVS=16, DLEN=8, i_div=3 (64 clk/bit), 8N1, send 0xA5, i_rready=1 -> o_rvalid 1-cycle pulse, o_rdata=0xA5, perr=ferr=brk=0.
- Even parity, send 0x07 with parity bit 1 -> rdata=0x07, perr=0. Repeat with parity bit 0 -> perr=1. Odd parity, 0x07 with parity 0 -> perr=0.
- 0-pulse of 20 clk (<half bit) on idle line -> FSM returns IDLE, no o_rvalid. Then 1-clk glitch at each vote point of a 0x3C frame -> rdata=0x3C (majority vote).
- i_stop2=1, second stop bit driven 0 -> ferr=1, brk=0. Line held low 12 bits -> rdata=0x00, ferr=1, brk=1; no second frame until line high, then 0x55 received clean.
- i_rready=0, send 0x11 then 0x22 -> o_ovr pulses once, o_rdata stays 0x11. Assert i_rready -> buffer cleared. Completion coincident with i_rready -> 0x33 loaded with no o_ovr.
- Change i_div 3->7 mid-frame -> current frame decodes at old rate; next frame at 128 clk/bit decodes correctly. Assert rstn low mid-data -> all outputs 0, next frame 0x81 decodes correctly.

Source files
------------

// File: rtl/uart_rx_ovs.sv
// UART receiver with input synchroniser, OVS-times oversampling and 3-sample majority vote,
// runtime baud divisor, optional parity, 1 or 2 stop bits and a valid/ready output buffer.
module uart_rx_ovs #(
    parameter int unsigned DLEN = 8,
    parameter int unsigned OVS  = 16,
    parameter int unsigned DIVW = 16,
    parameter int unsigned SYNC = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_rxs,
    input  logic [DIVW-1:0] i_div,
    input  logic            i_par_en,
    input  logic            i_par_odd,
    input  logic            i_stop2,
    output logic            o_rvalid,
    input  logic            i_rready,
    output logic [DLEN-1:0] o_rdata,
    output logic            o_perr,
    output logic            o_ferr,
    output logic            o_brk,
    output logic            o_ovr
);

    localparam int unsigned OSW = $clog2(OVS);
    localparam int unsigned BCW = $clog2(DLEN + 1);
    localparam logic [OSW-1:0] OS_S0   = OSW'(OVS / 2 - 1);
    localparam logic [OSW-1:0] OS_S1   = OSW'(OVS / 2);
    localparam logic [OSW-1:0] OS_VOTE = OSW'(OVS / 2 + 1);
    localparam logic [OSW-1:0] OS_END  = OSW'(OVS - 1);
    localparam logic [BCW-1:0] BC_LAST = BCW'(DLEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2,
        S_BRKWAIT
    } state_t;

    logic [SYNC-1:0] sync_q;
    logic            rxs;

    state_t          state_q;
    logic [DIVW-1:0] div_ct_q;
    logic [DIVW-1:0] div_l_q;
    logic [OSW-1:0]  os_ct_q;
    logic [BCW-1:0]  bit_ct_q;
    logic [DLEN-1:0] shreg_q;
    logic [1:0]      smp_q;
    logic            par_en_l_q;
    logic            par_odd_l_q;
    logic            stop2_l_q;
    logic            par_v_q;
    logic            perr_q;

    logic            counting;
    logic            tick;
    logic            at_vote;
    logic            at_end;
    logic            vote;
    logic            done_d;
    logic            ferr_d;
    logic            brk_d;

    logic            rvalid_q;
    logic [DLEN-1:0] rdata_q;
    logic            perr_o_q;
    logic            ferr_q;
    logic            brk_q;
    logic            ovr_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC-2:0], i_rxs};
        end
    end

    assign rxs = sync_q[SYNC-1];

    assign counting = (state_q != S_IDLE) && (state_q != S_BRKWAIT);
    assign tick     = counting && (div_ct_q == div_l_q);
    assign at_vote  = tick && (os_ct_q == OS_VOTE);
    assign at_end   = tick && (os_ct_q == OS_END);
    assign vote     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);

    // Completion fires on the last stop vote tick, not at the end of the stop bit.
    always_comb begin
        done_d = 1'b0;
        ferr_d = 1'b0;
        brk_d  = 1'b0;
        if (at_vote) begin
            case (state_q)
                S_STOP1: begin
                    if (!stop2_l_q || !vote) begin
                        done_d = 1'b1;
                        ferr_d = !vote;
                        brk_d  = (shreg_q == '0) && !(par_en_l_q && par_v_q) && !vote;
                    end
                end
                S_STOP2: begin
                    done_d = 1'b1;
                    ferr_d = !vote;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            div_ct_q    <= '0;
            div_l_q     <= '0;
            os_ct_q     <= '0;
            bit_ct_q    <= '0;
            shreg_q     <= '0;
            smp_q       <= '0;
            par_en_l_q  <= 1'b0;
            par_odd_l_q <= 1'b0;
            stop2_l_q   <= 1'b0;
            par_v_q     <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            if (!counting) begin
                div_ct_q <= '0;
                os_ct_q  <= '0;
            end else if (tick) begin
                div_ct_q <= '0;
                os_ct_q  <= (os_ct_q == OS_END) ? '0 : os_ct_q + 1'b1;
            end else begin
                div_ct_q <= div_ct_q + 1'b1;
            end

            if (tick && (os_ct_q == OS_S0)) smp_q[0] <= rxs;
            if (tick && (os_ct_q == OS_S1)) smp_q[1] <= rxs;

            case (state_q)
                S_IDLE: begin
                    if (!rxs) begin
                        state_q     <= S_START;
                        div_l_q     <= i_div;
                        par_en_l_q  <= i_par_en;
                        par_odd_l_q <= i_par_odd;
                        stop2_l_q   <= i_stop2;
                        bit_ct_q    <= '0;
                        par_v_q     <= 1'b0;
                        perr_q      <= 1'b0;
                    end
                end
                S_START: begin
                    if (at_vote && vote) state_q <= S_IDLE;
                    else if (at_end)     state_q <= S_DATA;
                end
                S_DATA: begin
                    if (at_vote) begin
                        shreg_q  <= {vote, shreg_q[DLEN-1:1]};
                        bit_ct_q <= bit_ct_q + 1'b1;
                    end
                    if (at_end && (bit_ct_q == BC_LAST)) begin
                        state_q <= par_en_l_q ? S_PARITY : S_STOP1;
                    end
                end
                S_PARITY: begin
                    if (at_vote) begin
                        par_v_q <= vote;
                        perr_q  <= vote != (^shreg_q ^ par_odd_l_q);
                    end
                    if (at_end) state_q <= S_STOP1;
                end
                S_STOP1: begin
                    if (at_vote) begin
                        if (!(stop2_l_q && vote)) state_q <= vote ? S_IDLE : S_BRKWAIT;
                    end else if (at_end) begin
                        state_q <= S_STOP2;
                    end
                end
                S_STOP2: begin
                    if (at_vote) state_q <= vote ? S_IDLE : S_BRKWAIT;
                end
                S_BRKWAIT: begin
                    if (rxs) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // A completion coinciding with i_rready replaces the consumed frame without overrun.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            perr_o_q <= 1'b0;
            ferr_q   <= 1'b0;
            brk_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (done_d) begin
                if (!rvalid_q || i_rready) begin
                    rvalid_q <= 1'b1;
                    rdata_q  <= shreg_q;
                    perr_o_q <= par_en_l_q && perr_q;
                    ferr_q   <= ferr_d;
                    brk_q    <= brk_d;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (i_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign o_rvalid = rvalid_q;
    assign o_rdata  = rdata_q;
    assign o_perr   = perr_o_q;
    assign o_ferr   = ferr_q;
    assign o_brk    = brk_q;
    assign o_ovr    = ovr_q;

endmodule
